lsu_req_queue: RTL and testbench
================================

Name: lsu_req_queue

Overview:
- Request queue directly upstream of the load unit and the store unit.
- Buffers issued LSU operations (lsu_ctrl_t) in program order and presents the head entry as a load request or a store request.
- Retires the head on pop_ld_i or pop_st_i.
- Provides a zero-latency bypass when empty and drops all entries on flush_i.

Parameters:
- lsu_ctrl_t, logic, packed request struct; must contain fields valid, vaddr, be, operation, pointer, is_load.
- DEPTH, 2, number of queue entries; must be 2 or more, and need not be a power of two.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush; drops all entries.
- valid_i  in  1  issue stage offers a request.
- lsu_ctrl_i  in  $bits(lsu_ctrl_t)  offered request.
- ready_o  out  1  queue can accept a request this cycle.
- ld_valid_o  out  1  head is a valid load.
- st_valid_o  out  1  head is a valid store.
- lsu_ctrl_o  out  $bits(lsu_ctrl_t)  head request, shared by both units.
- pop_ld_i  in  1  load unit consumed the head.
- pop_st_i  in  1  store unit consumed the head.
- count_o  out  $clog2(DEPTH)+1  current occupancy (debug and perf).

Behaviour:
- **Storage:** circular buffer of DEPTH entries.
  - Read pointer rptr_q and write pointer wptr_q, each $clog2(DEPTH) bits.
  - Occupancy count_q, $clog2(DEPTH)+1 bits.
  - A pointer equal to DEPTH-1 wraps to 0 on increment; there is no reliance on power-of-two overflow.
- **Reset:** rptr_q = 0, wptr_q = 0, count_q = 0, all entry storage = '0.
  - Output values at reset: ld_valid_o = 0, st_valid_o = 0, ready_o = 1, lsu_ctrl_o = '0, count_o = 0.
- **ready_o:** equals (count_q != DEPTH) and is independent of the pop inputs, so there is no comb path from pop to ready.
- **push:** push = valid_i & ready_o & ~flush_i. On push, write lsu_ctrl_i into entry wptr_q and advance wptr_q.
- **Head selection (combinational):**
  - If count_q == 0, the head is lsu_ctrl_i (bypass) and head_v = valid_i & ~flush_i.
  - Otherwise the head is entry rptr_q and head_v = 1.
- **Head outputs:**
  - lsu_ctrl_o = head whenever head_v, else '0.
  - ld_valid_o = head_v & head.is_load.
  - st_valid_o = head_v & ~head.is_load.
- **pop:**
  - pop = (pop_ld_i & ld_valid_o) | (pop_st_i & st_valid_o).
  - A pop whose type does not match the head is ignored, and an assertion fires.
  - pop_ld_i and pop_st_i asserted together is illegal (assertion).
- **Bypass pop:** when count_q == 0 and a bypass request is popped in the same cycle, the entry is written and read in that cycle.
  - Both pointers advance and count stays 0, so the request never occupies storage.
- **Count update:** count_d = count_q + push - pop.
  - Simultaneous push and pop when full is impossible, because push requires ready_o.
  - Simultaneous push and pop when not full leaves the count unchanged.
- **Latency:** 0 cycles from valid_i to ld_valid_o/st_valid_o when empty. Otherwise a request waits behind older entries in strict FIFO order.
- **Head stability:** the head is held stable (valid and data) until popped; the downstream unit may take any number of cycles.
- **flush_i:** effective at the next edge.
  - rptr_q, wptr_q and count_q return to 0.
  - In the flush cycle, push is suppressed and ld_valid_o/st_valid_o are forced to 0.
  - Any pop in the flush cycle is discarded.
- **No internal FSM beyond the counters.** Legal occupancy states are EMPTY (count 0), PARTIAL and FULL (count DEPTH).
  - EMPTY→PARTIAL on push without pop.
  - PARTIAL→FULL on push without pop at count DEPTH-1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push at count 1.
  - Any state→EMPTY on flush.
- **Reset mid-operation:** asynchronous return to the reset values, regardless of pending pops.

Decomposition:
- Shared package config_pkg:
  - LSU_REQ_DEPTH constant.
  - lsu_ctrl_t definition including the is_load field.
  - POINTER_SIZE, VLEN and XLEN constants already used by lsu_ctrl_t.
- Sub-module: none required. The module is a single RTL file containing the pointer/count logic, the bypass mux, and assertions under translate_off.

Test Plan:
1. Bypass: reset, empty queue, valid_i = 1 with load pointer = 3, pop_ld_i = 1 in the same cycle → ld_valid_o = 1 and lsu_ctrl_o.pointer = 3 that cycle; next cycle count_o = 0 and ld_valid_o = 0.
2. Fill and stall with DEPTH = 2: push store ptr = 1, then load ptr = 2, with no pops → count_o = 2, ready_o = 0, st_valid_o = 1 with pointer = 1; a third valid_i is not accepted and count_o stays 2.
3. In-order drain: from test 2, pop_st_i → next cycle ld_valid_o = 1 with pointer = 2 and count_o = 1; pop_ld_i → count_o = 0.
4. Wrap-around with DEPTH = 3: 7 pushes interleaved with pops so the count never exceeds 3 → pointer order out equals 0..6; rptr and wptr each wrap twice with no loss or duplicate.
5. Simultaneous push and pop at count 1 → count_o stays 1 and the head becomes the newly pushed entry on the following cycle.
6. Flush: count_o = 2 with valid_i = 1 and pop_st_i = 1 in the flush cycle → ld_valid_o = 0 and st_valid_o = 0 that cycle; next cycle count_o = 0 and ready_o = 1; a mismatched pop (pop_ld_i while head is a store) triggers the assertion and does not change count.

Source files
------------

// File: rtl/config_pkg.sv
// Shared core configuration: widths and the LSU request bundle
// handed from issue to the load/store units.
package config_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned VLEN          = 39;
    localparam int unsigned POINTER_SIZE  = 4;
    localparam int unsigned LSU_REQ_DEPTH = 2;

    typedef enum logic [1:0] {
        OP_LD,
        OP_ST,
        OP_LR,
        OP_SC
    } fu_op_t;

    typedef struct packed {
        logic                    valid;
        logic [VLEN-1:0]         vaddr;
        logic [XLEN/8-1:0]       be;
        fu_op_t                  operation;
        logic [POINTER_SIZE-1:0] pointer;
        logic                    is_load;
    } lsu_ctrl_t;

endpackage

// File: rtl/lsu_req_queue.sv
// In-order request queue in front of the load and store units,
// with a same-cycle bypass when empty.
module lsu_req_queue #(
    parameter type         lsu_ctrl_t = config_pkg::lsu_ctrl_t,
    parameter int unsigned DEPTH      = config_pkg::LSU_REQ_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    input  lsu_ctrl_t                lsu_ctrl_i,
    output logic                     ready_o,
    output logic                     ld_valid_o,
    output logic                     st_valid_o,
    output lsu_ctrl_t                lsu_ctrl_o,
    input  logic                     pop_ld_i,
    input  logic                     pop_st_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    lsu_ctrl_t     mem_q [DEPTH];
    logic [PW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] count_q;

    logic      empty, push, pop, head_v;
    lsu_ctrl_t head;

    // Explicit wrap so non power-of-two depths work.
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign ready_o = (count_q != FULL);
    assign push    = valid_i & ready_o & ~flush_i;
    assign count_o = count_q;

    always_comb begin
        head   = mem_q[rptr_q];
        head_v = 1'b1;
        if (empty) begin
            head   = lsu_ctrl_i;
            head_v = valid_i & ~flush_i;
        end
    end

    assign lsu_ctrl_o = head_v ? head : '0;
    assign ld_valid_o = head_v & ~flush_i & head.is_load;
    assign st_valid_o = head_v & ~flush_i & ~head.is_load;
    assign pop = (pop_ld_i & ld_valid_o) | (pop_st_i & st_valid_o);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            // A bypassed pop also writes and advances both pointers.
            if (push) begin
                mem_q[wptr_q] <= lsu_ctrl_i;
                wptr_q        <= inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= inc(rptr_q);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(pop_ld_i && pop_st_i))
                else $error("lsu_req_queue: load and store pop together");
            assert (!((pop_ld_i && st_valid_o) || (pop_st_i && ld_valid_o)))
                else $warning("lsu_req_queue: pop type does not match head");
        end
    end
`endif

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed bench for lsu_req_queue at depth 2 and depth 3,
// with a pointer scoreboard checking program order.
module tb_lsu_req_queue;
    import config_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic      a_flush, a_valid, a_pop_ld, a_pop_st;
    logic      a_ready, a_ldv, a_stv;
    lsu_ctrl_t a_in, a_out;
    logic [1:0] a_cnt;

    logic      b_flush, b_valid, b_pop_ld, b_pop_st;
    logic      b_ready, b_ldv, b_stv;
    lsu_ctrl_t b_in, b_out;
    logic [2:0] b_cnt;

    lsu_req_queue #(.lsu_ctrl_t(lsu_ctrl_t), .DEPTH(2)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
        .valid_i(a_valid), .lsu_ctrl_i(a_in), .ready_o(a_ready),
        .ld_valid_o(a_ldv), .st_valid_o(a_stv), .lsu_ctrl_o(a_out),
        .pop_ld_i(a_pop_ld), .pop_st_i(a_pop_st), .count_o(a_cnt)
    );

    lsu_req_queue #(.lsu_ctrl_t(lsu_ctrl_t), .DEPTH(3)) u_d3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
        .valid_i(b_valid), .lsu_ctrl_i(b_in), .ready_o(b_ready),
        .ld_valid_o(b_ldv), .st_valid_o(b_stv), .lsu_ctrl_o(b_out),
        .pop_ld_i(b_pop_ld), .pop_st_i(b_pop_st), .count_o(b_cnt)
    );

    int npass = 0;
    int ntotal = 0;
    int nfail = 0;
    int sb[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic lsu_ctrl_t mk(input int ptr, input logic ld);
        lsu_ctrl_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.vaddr     = VLEN'(ptr * 8);
        r.be        = '1;
        r.operation = ld ? OP_LD : OP_ST;
        r.pointer   = POINTER_SIZE'(ptr);
        r.is_load   = ld;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag);
        int e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, 64'(a_out.pointer), 64'(e));
        end
    endtask

    initial begin
        int got, exp_ptr, cyc;
        logic dop;
        a_flush = 0; a_valid = 0; a_pop_ld = 0; a_pop_st = 0; a_in = '0;
        b_flush = 0; b_valid = 0; b_pop_ld = 0; b_pop_st = 0; b_in = '0;

        // reset values
        #12;
        chk("rst_ldv", 64'(a_ldv), 64'd0);
        chk("rst_stv", 64'(a_stv), 64'd0);
        chk("rst_ready", 64'(a_ready), 64'd1);
        chk("rst_cnt", 64'(a_cnt), 64'd0);
        chk("rst_ctrl", {63'd0, a_out === lsu_ctrl_t'('0)}, 64'd1);
        tick();
        rst_n = 1'b1;

        // bypass load with same-cycle pop
        tick();
        a_valid = 1; a_in = mk(3, 1'b1); a_pop_ld = 1;
        #1;
        chk("byp_ldv", 64'(a_ldv), 64'd1);
        chk("byp_stv", 64'(a_stv), 64'd0);
        chk("byp_ptr", 64'(a_out.pointer), 64'd3);
        tick();
        a_valid = 0; a_pop_ld = 0;
        #1;
        chk("byp_cnt", 64'(a_cnt), 64'd0);
        chk("byp_ldv_after", 64'(a_ldv), 64'd0);

        // fill to full and stall
        tick();
        a_valid = 1; a_in = mk(1, 1'b0); sb.push_back(1);
        #1;
        chk("fill_byp_stv", 64'(a_stv), 64'd1);
        tick();
        a_in = mk(2, 1'b1); sb.push_back(2);
        tick();
        a_in = mk(7, 1'b1);
        #1;
        chk("full_cnt", 64'(a_cnt), 64'd2);
        chk("full_ready", 64'(a_ready), 64'd0);
        chk("full_stv", 64'(a_stv), 64'd1);
        chk("full_ptr", 64'(a_out.pointer), 64'd1);
        tick();
        a_valid = 0;
        #1;
        chk("stall_cnt", 64'(a_cnt), 64'd2);

        // in-order drain
        tick();
        a_pop_st = 1;
        #1;
        chk_head("drain_st_ptr");
        tick();
        a_pop_st = 0;
        #1;
        chk("drain_ldv", 64'(a_ldv), 64'd1);
        chk("drain_cnt1", 64'(a_cnt), 64'd1);
        chk_head("drain_ld_ptr");
        a_pop_ld = 1;
        tick();
        a_pop_ld = 0;
        #1;
        chk("drain_cnt0", 64'(a_cnt), 64'd0);

        // push and pop together at count 1
        tick();
        a_valid = 1; a_in = mk(4, 1'b1);
        tick();
        a_in = mk(5, 1'b0); a_pop_ld = 1;
        #1;
        chk("pp_old_ptr", 64'(a_out.pointer), 64'd4);
        tick();
        a_valid = 0; a_pop_ld = 0;
        #1;
        chk("pp_cnt", 64'(a_cnt), 64'd1);
        chk("pp_stv", 64'(a_stv), 64'd1);
        chk("pp_new_ptr", 64'(a_out.pointer), 64'd5);
        a_pop_st = 1;
        tick();
        a_pop_st = 0;
        #1;
        chk("pp_drain_cnt", 64'(a_cnt), 64'd0);

        // flush with push and pop pending
        a_valid = 1; a_in = mk(8, 1'b0);
        tick();
        a_in = mk(9, 1'b1);
        tick();
        a_flush = 1; a_in = mk(10, 1'b1); a_pop_st = 1;
        #1;
        chk("fl_cnt_before", 64'(a_cnt), 64'd2);
        chk("fl_ldv", 64'(a_ldv), 64'd0);
        chk("fl_stv", 64'(a_stv), 64'd0);
        tick();
        a_flush = 0; a_valid = 0; a_pop_st = 0;
        #1;
        chk("fl_cnt", 64'(a_cnt), 64'd0);
        chk("fl_ready", 64'(a_ready), 64'd1);

        // mismatched pop is ignored
        a_valid = 1; a_in = mk(11, 1'b0);
        tick();
        a_valid = 0; a_pop_ld = 1;
        #1;
        chk("mm_stv", 64'(a_stv), 64'd1);
        tick();
        a_pop_ld = 0;
        #1;
        chk("mm_cnt", 64'(a_cnt), 64'd1);
        chk("mm_ptr", 64'(a_out.pointer), 64'd11);
        a_pop_st = 1;
        tick();
        a_pop_st = 0;
        #1;
        chk("mm_drain_cnt", 64'(a_cnt), 64'd0);

        // wrap-around at depth 3 with random pops
        sb.delete();
        got = 0; exp_ptr = 0; cyc = 0;
        while (got < 7 && cyc < 200) begin
            tick();
            cyc++;
            b_valid = 0; b_pop_ld = 0; b_pop_st = 0;
            if (exp_ptr < 7 && b_ready) begin
                b_valid = 1;
                b_in = mk(exp_ptr, exp_ptr[0]);
                sb.push_back(exp_ptr);
                exp_ptr++;
            end
            #1;
            dop = ($urandom_range(0, 1) == 1) || exp_ptr == 7;
            if (dop && (b_ldv || b_stv)) begin
                if (sb.size() == 0) begin
                    chk("wrap_sb_empty", 64'd1, 64'd0);
                end else begin
                    chk("wrap_order", 64'(b_out.pointer), 64'(sb.pop_front()));
                end
                b_pop_ld = b_ldv;
                b_pop_st = b_stv;
                got++;
            end
            chk("wrap_cnt_le3", 64'(b_cnt <= 3'd3), 64'd1);
        end
        tick();
        b_valid = 0; b_pop_ld = 0; b_pop_st = 0;
        #1;
        chk("wrap_done", 64'(got), 64'd7);
        chk("wrap_cnt", 64'(b_cnt), 64'd0);
        chk("wrap_sb_left", 64'(sb.size()), 64'd0);

        // async reset mid-operation
        b_valid = 1; b_in = mk(2, 1'b1);
        tick();
        b_valid = 0;
        #1;
        chk("ar_cnt_pre", 64'(b_cnt), 64'd1);
        b_pop_ld = 1;
        rst_n = 0;
        #1;
        chk("ar_cnt", 64'(b_cnt), 64'd0);
        chk("ar_ldv", 64'(b_ldv), 64'd0);
        b_pop_ld = 0;
        tick();
        rst_n = 1;

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
